// File: rtl/freq_gate_sequencer_if.sv
// Handshake/bus bundle between the frequency-meter controller, its consumer and the edge counter.
interface freq_gate_sequencer_if #(
  parameter int CNT_W  = 40,
  parameter int GATE_W = 32
);
  logic              start;
  logic              continuous;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              gate_out;
  logic [CNT_W-1:0]  count_in;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              stale;
  logic              overrun;
  logic              busy;

  modport master (
    output start, continuous, abort, gate_len, count_in, result_ready,
    input  gate_out, result, result_valid, stale, overrun, busy
  );

  modport slave (
    input  start, continuous, abort, gate_len, count_in, result_ready,
    output gate_out, result, result_valid, stale, overrun, busy
  );
endinterface

// File: rtl/freq_gate_sequencer.sv
// Gate sequencer for the asynchronous edge counter: clear, gate, settle, capture,
// and present each count as a valid/ready result with stale/overrun flags.
module freq_gate_sequencer #(
  parameter int CNT_W         = 40,
  parameter int GATE_W        = 32,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input logic                 clk,
  input logic                 reset,
  freq_gate_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, GATE, SETTLE, CAPTURE} state_t;

  localparam logic [GATE_W-1:0] CLEAR_LOAD  = GATE_W'(CLEAR_CYCLES - 1);
  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);

  state_t            state, state_next;
  logic [GATE_W-1:0] timer;
  logic [GATE_W-1:0] len_q;
  logic              cont_mode;
  logic [CNT_W-1:0]  result_q;
  logic [CNT_W-1:0]  prev_capture;
  logic              result_valid_q;
  logic              stale_q;
  logic              overrun_q;
  logic              timer_zero;
  logic              start_ok;
  logic              capture_ok;

  assign timer_zero = (timer == '0);
  assign start_ok   = (state == IDLE) && bus.start && !bus.abort;
  assign capture_ok = (state == CAPTURE) && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ARM;
      ARM:     if (timer_zero) state_next = GATE;
      GATE:    if (timer_zero) state_next = SETTLE;
      SETTLE:  if (timer_zero) state_next = CAPTURE;
      CAPTURE: state_next = cont_mode ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  always_comb begin
    bus.gate_out = (state == GATE);
    bus.busy     = (state != IDLE);
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.stale        = stale_q;
  assign bus.overrun      = overrun_q;

  // Timer is loaded on every state entry and otherwise counts down to zero and holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer          <= '0;
      len_q          <= '0;
      cont_mode      <= 1'b0;
      result_q       <= '0;
      prev_capture   <= '0;
      result_valid_q <= 1'b0;
      stale_q        <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (state_next != state) begin
        case (state_next)
          ARM:     timer <= CLEAR_LOAD;
          GATE:    timer <= len_q - 1'b1;
          SETTLE:  timer <= SETTLE_LOAD;
          default: timer <= timer;
        endcase
      end else if (!timer_zero) begin
        timer <= timer - 1'b1;
      end

      if (start_ok) begin
        len_q     <= (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
        cont_mode <= bus.continuous;
        overrun_q <= 1'b0;
      end

      // A capture coinciding with an accept takes precedence and is not an overrun.
      if (capture_ok) begin
        result_q       <= bus.count_in;
        stale_q        <= (bus.count_in == prev_capture);
        prev_capture   <= bus.count_in;
        result_valid_q <= 1'b1;
        if (result_valid_q && !bus.result_ready) overrun_q <= 1'b1;
      end else if (result_valid_q && bus.result_ready) begin
        result_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/freq_gate_sequencer.md
Name: freq_gate_sequencer

Overview:
- Single-clock controller that sequences the asynchronous edge-counter block of the frequency meter.
- Generates its gate (`period`) signal with a programmable length in clk cycles, and holds the gate low long enough for the counter to clear.
- Waits for the counter's asynchronous latch to settle, then captures `counter_out` into the clk domain.
- Presents each capture as a valid/ready result, with stale and overrun flags; supports single-shot and continuous measurement.

Parameters:
- CNT_W, 40: width of the counter result bus.
- GATE_W, 32: width of the gate length (clk cycles).
- CLEAR_CYCLES, 4: gate-low cycles before each gate so the counter sees `period`=0 and clears; min 1.
- SETTLE_CYCLES, 8: cycles after gate falls before `count_in` is sampled; min 1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a measurement; honoured only in IDLE.
- continuous  in  1  sampled with start: 1 = repeat measurements until abort.
- abort  in  1  stop any measurement, return to IDLE.
- gate_len  in  GATE_W  gate-high length in clk cycles; latched at start; 0 is treated as 1.
- gate_out  out  1  drives the counter's `period` input.
- count_in  in  CNT_W  the counter's `counter_out`.
- result  out  CNT_W  captured count.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- stale  out  1  captured value equals the previous capture (no input edges during the gate).
- overrun  out  1  sticky: a capture occurred while result_valid was still 1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE; gate_out=0, result=0, result_valid=0, stale=0, overrun=0, busy=0; internal prev_capture=0, timer=0, cont_mode=0.
- Reset overrides everything, including a measurement in progress. gate_out drops in the same edge.
- States and transitions:
  - IDLE: gate_out=0. On start: latch gate_len (0→1) and continuous; clear overrun; go to ARM with timer=CLEAR_CYCLES-1.
  - ARM: gate_out=0. Decrement timer; at 0 go to GATE with timer=len-1.
  - GATE: gate_out=1. Decrement timer; at 0 go to SETTLE with timer=SETTLE_CYCLES-1. gate_out is high exactly len cycles.
  - SETTLE: gate_out=0. Decrement timer; at 0 go to CAPTURE.
  - CAPTURE: one cycle.
    - result<=count_in; stale<=(count_in==prev_capture); prev_capture<=count_in; result_valid<=1.
    - If result_valid is already 1 and not being accepted in this cycle, overrun<=1.
    - Next state: ARM (timer=CLEAR_CYCLES-1) if cont_mode, else IDLE.
- Latency: start sampled at edge 0.
  - gate_out rises at edge CLEAR_CYCLES and falls at edge CLEAR_CYCLES+len.
  - result_valid rises at edge CLEAR_CYCLES+len+SETTLE_CYCLES+1.
  - Continuous period is CLEAR_CYCLES+len+SETTLE_CYCLES+1 cycles.
- Handshake:
  - result_valid clears on the edge where result_valid&&result_ready.
  - result is stable while result_valid=1, except when a capture overwrites it (overrun case).
  - In the CAPTURE cycle with result_valid&&result_ready, the accept and the new capture coincide. The new result is valid and overrun is not set.
- abort: any state → IDLE next edge; gate_out=0 next edge; no capture. result/result_valid/flags are untouched. abort has priority over start in the same cycle.
- start while busy: ignored; gate_len and continuous changes mid-measurement are ignored.
- Timer is GATE_W bits wide, loads down-counts only, and never wraps.
- overrun: cleared by reset or an accepted start only.
- Counter domain: the counter clears on input edges while gate is low and latches on the gate falling edge.
  - CLEAR_CYCLES must cover at least one input edge period for a guaranteed clear.
  - A stale result is reported via `stale`, not suppressed.

Test Plan:
- Single-shot, CLEAR=4, SETTLE=8, gate_len=100, count_in set to 40'd2500 at gate fall:
  - gate_out high for exactly 100 cycles starting edge 4.
  - result_valid at edge 113, result=2500, stale=0, busy low after edge 113.
- gate_len=0: gate_out high exactly 1 cycle; result_valid at edge 14.
- Continuous, gate_len=10, result_ready held 1, count_in 7 then 9 then 9:
  - results 7, 9, 9 every 23 cycles; stale=0, 0, 1; overrun stays 0.
- Continuous, result_ready held 0: second capture sets overrun=1 and result updates.
  - overrun stays 1 after ready returns; cleared only by the next start from IDLE.
- abort asserted mid-GATE (cycle 50 of 100): gate_out 0 next edge, state IDLE, no result_valid.
  - start together with abort in IDLE → remains IDLE.
- reset asserted in SETTLE with result_valid=1: all outputs return to reset values next edge.
  - A later start with count_in=0 yields stale=1 (prev_capture reset to 0).
